fp_outfifo_buf: RTL

- Agent output FIFO sitting directly downstream of the 32-bit output port.
- Accepts data words plus packet tags written by the port over the ag_ofifo interface.
- Reports full and occupancy back to the port.
- Presents entries first-word-fall-through to the downstream accumulator/egress reader.

---
 rtl/fp_outfifo_buf_if.sv | 37 +++
 rtl/fp_outfifo_buf.sv | 100 ++++++++++
 2 files changed

// File: rtl/fp_outfifo_buf_if.sv
// Agent output FIFO bus: write side from the output port, FWFT read side to the
// downstream reader, and the sticky error flags.
interface fp_outfifo_if #(
   parameter int AW = 4,
   parameter int DW = 32,
   parameter int TW = 16
);
   logic          ag_ofifo_ifc_ff_fp_outfifo_write;
   logic [DW-1:0] ag_ofifo_ifc_ff_fp_outfifo_data;
   logic [TW-1:0] ag_ofifo_ifc_ff_fp_outfifo_pkt_tag;
   logic          ag_ofifo_ifc_ff_fp_outfifo_full;
   logic [AW:0]   ag_ofifo_ifc_ff_fp_outfifo_full_count;
   logic          fp_outfifo_rd;
   logic [DW-1:0] fp_outfifo_rd_data;
   logic [TW-1:0] fp_outfifo_rd_pkt_tag;
   logic          fp_outfifo_empty;
   logic          fp_outfifo_ovf_err;
   logic          fp_outfifo_udf_err;

   // FIFO-side view
   modport slave (
      input  ag_ofifo_ifc_ff_fp_outfifo_write, ag_ofifo_ifc_ff_fp_outfifo_data,
             ag_ofifo_ifc_ff_fp_outfifo_pkt_tag, fp_outfifo_rd,
      output ag_ofifo_ifc_ff_fp_outfifo_full, ag_ofifo_ifc_ff_fp_outfifo_full_count,
             fp_outfifo_rd_data, fp_outfifo_rd_pkt_tag, fp_outfifo_empty,
             fp_outfifo_ovf_err, fp_outfifo_udf_err
   );

   // Port/reader-side view
   modport master (
      output ag_ofifo_ifc_ff_fp_outfifo_write, ag_ofifo_ifc_ff_fp_outfifo_data,
             ag_ofifo_ifc_ff_fp_outfifo_pkt_tag, fp_outfifo_rd,
      input  ag_ofifo_ifc_ff_fp_outfifo_full, ag_ofifo_ifc_ff_fp_outfifo_full_count,
             fp_outfifo_rd_data, fp_outfifo_rd_pkt_tag, fp_outfifo_empty,
             fp_outfifo_ovf_err, fp_outfifo_udf_err
   );
endinterface

// File: rtl/fp_outfifo_buf.sv
// Agent output FIFO, first-word-fall-through with registered head outputs.
// Define FP_OUTFIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module fp_outfifo_buf #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int DW    = 32,
   parameter int TW    = 16
) (
   input  logic        clk,
   input  logic        reset,
   fp_outfifo_if.slave ofifo
);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DW+TW-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             full_q, empty_q;
   logic [DW-1:0]    rd_data_q, rd_data_d;
   logic [TW-1:0]    rd_tag_q, rd_tag_d;
   logic             wr_acc, rd_acc, bypass;

   assign wr_acc = ofifo.ag_ofifo_ifc_ff_fp_outfifo_write & ~full_q & ~reset;
   assign rd_acc = ofifo.fp_outfifo_rd & ~empty_q;

   always_comb begin
      wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
      // New head is the slot being written this edge: take it straight from the port
      bypass    = wr_acc && (rd_ptr_d == wr_ptr_q);
      rd_data_d = rd_data_q;
      rd_tag_d  = rd_tag_q;
      if (count_d != '0) begin
         if (bypass) begin
            rd_data_d = ofifo.ag_ofifo_ifc_ff_fp_outfifo_data;
            rd_tag_d  = ofifo.ag_ofifo_ifc_ff_fp_outfifo_pkt_tag;
         end else begin
            {rd_tag_d, rd_data_d} = mem_q[rd_ptr_d];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc)
         mem_q[wr_ptr_q] <= {ofifo.ag_ofifo_ifc_ff_fp_outfifo_pkt_tag,
                             ofifo.ag_ofifo_ifc_ff_fp_outfifo_data};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
         rd_data_q <= '0;
         rd_tag_q  <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         full_q    <= (count_d == FULL_CNT);
         empty_q   <= (count_d == '0);
         rd_data_q <= rd_data_d;
         rd_tag_q  <= rd_tag_d;
      end
   end

   assign ofifo.ag_ofifo_ifc_ff_fp_outfifo_full       = full_q;
   assign ofifo.ag_ofifo_ifc_ff_fp_outfifo_full_count = count_q;
   assign ofifo.fp_outfifo_empty                      = empty_q;
   assign ofifo.fp_outfifo_rd_data                    = rd_data_q;
   assign ofifo.fp_outfifo_rd_pkt_tag                 = rd_tag_q;

`ifdef FP_OUTFIFO_ERR_FLAGS_EN
   logic ovf_q, udf_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_q | (ofifo.ag_ofifo_ifc_ff_fp_outfifo_write & full_q);
         udf_q <= udf_q | (ofifo.fp_outfifo_rd & empty_q);
      end
   end

   assign ofifo.fp_outfifo_ovf_err = ovf_q;
   assign ofifo.fp_outfifo_udf_err = udf_q;
`else
   assign ofifo.fp_outfifo_ovf_err = 1'b0;
   assign ofifo.fp_outfifo_udf_err = 1'b0;
`endif
endmodule
